// File: rtl/fsm_stim_driver_pkg.sv
// Shared definitions for the FSM stimulus driver.
//   state_e    : controller state encoding (exposed on the debug port)
//   DEPTH_DEF  : default number of stored (a,i) steps
package fsm_stim_driver_pkg;

  localparam int DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/fsm_stim_store.sv
// Pattern store for the stimulus driver: DEPTH entries of {a,i}, appended
// at index len, emptied by clr, read asynchronously at rd_ptr.
// Ports:
//   clk, rst_b        : clock, synchronous active-low reset (empties store)
//   clr               : empty the store (wins over wr)
//   wr, wr_a, wr_i    : append {wr_a, wr_i}; ignored when full
//   rd_ptr            : read index; rd_a/rd_i are the stored pair there
//   len, full         : stored step count, store holds DEPTH steps
module fsm_stim_store
  import fsm_stim_driver_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          clr,
  input  logic          wr,
  input  logic          wr_a,
  input  logic          wr_i,
  input  logic [CW-1:0] rd_ptr,
  output logic          rd_a,
  output logic          rd_i,
  output logic [CW-1:0] len,
  output logic          full
);

  // Entry index width; len/rd_ptr are one bit wider so they can hold DEPTH.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]    mem [DEPTH];
  logic [CW-1:0] len_q;
  logic          push;

  assign full = (len_q == CW'(DEPTH));
  assign len  = len_q;
  assign push = wr && !clr && !full;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      len_q <= '0;
    end else if (clr) begin
      len_q <= '0;
    end else if (push) begin
      len_q <= len_q + CW'(1);
    end
  end

  // Contents need no reset: entries at or beyond len are never read.
  always_ff @(posedge clk) begin
    if (rst_b && push) begin
      mem[len_q[AW-1:0]] <= {wr_a, wr_i};
    end
  end

  always_comb begin
    {rd_a, rd_i} = 2'b00;
    if (rd_ptr < CW'(DEPTH)) begin
      {rd_a, rd_i} = mem[rd_ptr[AW-1:0]];
    end
  end

endmodule

// File: rtl/fsm_stim_driver.sv
// Stimulus driver for two-input Mealy exercise FSMs. Stores up to DEPTH
// (a,i) steps, holds the target in reset for one cycle, plays one step per
// clock and counts the cycles each target output (o0/o5/o9) was high.
//
// Handshake: start is a single-cycle request honoured only in IDLE (err
// pulses if nothing is stored). busy is high while the run is in progress
// (PRE and RUN); done pulses for exactly one cycle after the last step, at
// which point cnt0/cnt5/cnt9 are valid and hold until the next start.
// clr/ld/start are ignored without err while busy.
//
// Ports:
//   clk, rst_b               : clock, synchronous active-low reset
//   clr, ld, ld_a, ld_i      : empty store / append step (IDLE only)
//   start                    : begin playback (IDLE only)
//   o0_in, o5_in, o9_in      : outputs returned by the target FSM
//   a_out, i_out, dut_rst_b  : target inputs and active-low target reset
//   busy, done, err          : status (done/err are one-cycle pulses)
//   full, len                : store status
//   cnt0, cnt5, cnt9         : high-cycle counts from the last run
//   dbg_state                : controller state for observation
// All outputs come from registers or registered state only.
module fsm_stim_driver
  import fsm_stim_driver_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  // Derived from DEPTH; leave at its default.
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          clr,
  input  logic          ld,
  input  logic          ld_a,
  input  logic          ld_i,
  input  logic          start,
  input  logic          o0_in,
  input  logic          o5_in,
  input  logic          o9_in,
  output logic          a_out,
  output logic          i_out,
  output logic          dut_rst_b,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          full,
  output logic [CW-1:0] len,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt5,
  output logic [CW-1:0] cnt9,
  output logic [1:0]    dbg_state
);

  state_e        state_q, state_d;
  logic [CW-1:0] ptr_q, ptr_nxt;
  logic [CW-1:0] cnt0_q, cnt5_q, cnt9_q;
  logic          err_q, err_d;
  logic          idle;
  logic          st_clr, st_wr;
  logic          rd_a, rd_i;

  assign idle    = (state_q == ST_IDLE);
  assign st_clr  = idle && clr;
  assign st_wr   = idle && ld;
  assign ptr_nxt = ptr_q + CW'(1);

  fsm_stim_store #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_store (
    .clk    (clk),
    .rst_b  (rst_b),
    .clr    (st_clr),
    .wr     (st_wr),
    .wr_a   (ld_a),
    .wr_i   (ld_i),
    .rd_ptr (ptr_q),
    .rd_a   (rd_a),
    .rd_i   (rd_i),
    .len    (len),
    .full   (full)
  );

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!clr) begin
          if (ld && full) begin
            err_d = 1'b1;
          end
          if (start) begin
            // A same-cycle ld counts toward the length being started.
            if ((len != '0) || (ld && !full)) begin
              state_d = ST_PRE;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      ST_PRE:  state_d = ST_RUN;
      ST_RUN:  if (ptr_nxt == len) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Read pointer and counters. o*_in seen at the end of RUN cycle k is the
  // target's Mealy response to pair k.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      ptr_q  <= '0;
      cnt0_q <= '0;
      cnt5_q <= '0;
      cnt9_q <= '0;
    end else if (state_q == ST_PRE) begin
      ptr_q  <= '0;
      cnt0_q <= '0;
      cnt5_q <= '0;
      cnt9_q <= '0;
    end else if (state_q == ST_RUN) begin
      ptr_q  <= ptr_nxt;
      cnt0_q <= cnt0_q + CW'(o0_in);
      cnt5_q <= cnt5_q + CW'(o5_in);
      cnt9_q <= cnt9_q + CW'(o9_in);
    end
  end

  assign a_out     = (state_q == ST_RUN) ? rd_a : 1'b0;
  assign i_out     = (state_q == ST_RUN) ? rd_i : 1'b0;
  assign dut_rst_b = (state_q != ST_PRE);
  assign busy      = (state_q == ST_PRE) || (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;
  assign cnt0      = cnt0_q;
  assign cnt5      = cnt5_q;
  assign cnt9      = cnt9_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fsm_stim_driver.sv
// Bench for fsm_stim_driver. A stand-in exercise FSM (table-driven Mealy
// machine, reset state H2) is looped back as the target. Expected counts
// come from walking the stored pattern through that table from H2.
module tb_fsm_stim_driver;
  import fsm_stim_driver_pkg::*;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  localparam int S_H2 = 0;
  localparam int S_D5 = 1;
  localparam int S_F6 = 2;
  localparam int S_V8 = 3;
  localparam int S_O8 = 4;

  // ---------------- clock / reset / signals ----------------
  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          clr = 1'b0, ld = 1'b0, ld_a = 1'b0, ld_i = 1'b0, start = 1'b0;
  logic          o0_in, o5_in, o9_in;
  logic          a_out, i_out, dut_rst_b, busy, done, err, full;
  logic [CW-1:0] len, cnt0, cnt5, cnt9;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  fsm_stim_driver #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .clr       (clr),
    .ld        (ld),
    .ld_a      (ld_a),
    .ld_i      (ld_i),
    .start     (start),
    .o0_in     (o0_in),
    .o5_in     (o5_in),
    .o9_in     (o9_in),
    .a_out     (a_out),
    .i_out     (i_out),
    .dut_rst_b (dut_rst_b),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .full      (full),
    .len       (len),
    .cnt0      (cnt0),
    .cnt5      (cnt5),
    .cnt9      (cnt9),
    .dbg_state (dbg_state)
  );

  // ---------------- target FSM (stand-in exercise machine) ----------------
  // o = {o0, o5, o9}. Listed transitions give the documented paths; the
  // rest follow an arbitrary but fixed rule.
  function automatic void tgt_step(input int st, input logic a, input logic i,
                                   output int nx, output logic [2:0] o);
    nx = (st + 2 * int'(a) + int'(i) + 1) % 5;
    o  = {a | i, a ^ i, (st % 2) == 1};
    case (st)
      S_H2: if (a && !i) begin nx = S_D5; o = 3'b101; end
            else if (!a && !i) begin nx = S_V8; o = 3'b000; end
      S_D5: if (!a && !i) begin nx = S_D5; o = 3'b110; end
            else if (!a && i) begin nx = S_F6; o = 3'b011; end
      S_F6: if (!a && !i) begin nx = S_F6; o = 3'b101; end
      S_V8: if (!a && !i) begin nx = S_O8; o = 3'b010; end
      S_O8: if (a && i) begin nx = S_F6; o = 3'b101; end
      default: ;
    endcase
  endfunction

  int         tgt_st = S_H2;
  int         tgt_nx;
  logic [2:0] tgt_o;

  always_comb tgt_step(tgt_st, a_out, i_out, tgt_nx, tgt_o);
  assign {o0_in, o5_in, o9_in} = tgt_o;

  always @(posedge clk) begin
    if (!dut_rst_b) tgt_st <= S_H2;
    else            tgt_st <= tgt_nx;
  end

  // ---------------- reference model / scoreboard ----------------
  logic [1:0] exp_q[$];   // expected store contents, {a,i} per step
  int n_checks = 0;
  int n_errors = 0;

  function automatic void model_counts(output int c0, output int c5, output int c9);
    int st, nx;
    logic [2:0] o;
    st = S_H2; c0 = 0; c5 = 0; c9 = 0;
    foreach (exp_q[k]) begin
      tgt_step(st, exp_q[k][1], exp_q[k][0], nx, o);
      c0 += int'(o[2]); c5 += int'(o[1]); c9 += int'(o[0]);
      st = nx;
    end
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ld(input logic a, input logic i);
    bit was_full;
    was_full = (exp_q.size() == DEPTH);
    ld = 1'b1; ld_a = a; ld_i = i;
    step();
    ld = 1'b0;
    if (!was_full) exp_q.push_back({a, i});
    check_eq("ld_err", 32'(err), 32'(was_full));
    check_eq("ld_len", 32'(len), exp_q.size());
    check_eq("ld_full", 32'(full), 32'(exp_q.size() == DEPTH));
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
    exp_q.delete();
    check_eq("clr_len", 32'(len), 0);
  endtask

  // Start a run (optionally with a same-cycle ld, optionally pulsing
  // ld/clr/start while busy) and check timing, handshake and counts.
  task automatic run_check(input string tag, input bit noise, input bit ld_w_start,
                           input logic la, input logic li,
                           output int c0, output int c5, output int c9);
    int n, low_cnt, run_cnt, e0, e5, e9, plen;
    bit got_done, err_seen;
    if (ld_w_start && exp_q.size() < DEPTH) exp_q.push_back({la, li});
    plen = exp_q.size();
    start = 1'b1; ld = ld_w_start; ld_a = la; ld_i = li;
    step();
    start = 1'b0; ld = 1'b0;
    n = 1; run_cnt = 0; got_done = 1'b0; err_seen = err;
    low_cnt = dut_rst_b ? 0 : 1;
    check_eq({tag, "_busy_pre"}, 32'(busy), 1);
    while (!got_done && n < plen + 10) begin
      if (noise && n == 2) begin ld = 1'b1; clr = 1'b1; start = 1'b1; end
      step();
      ld = 1'b0; clr = 1'b0; start = 1'b0;
      n++;
      if (!dut_rst_b) low_cnt++;
      if (busy && dut_rst_b) run_cnt++;
      err_seen |= err;
      if (done) got_done = 1'b1;
    end
    check_eq({tag, "_done_seen"}, 32'(got_done), 1);
    check_eq({tag, "_latency"}, n, plen + 2);
    check_eq({tag, "_rst_cycles"}, low_cnt, 1);
    check_eq({tag, "_run_cycles"}, run_cnt, plen);
    check_eq({tag, "_no_err"}, 32'(err_seen), 0);
    check_eq({tag, "_busy_done"}, 32'(busy), 0);
    check_eq({tag, "_a_done"}, 32'({a_out, i_out}), 0);
    model_counts(e0, e5, e9);
    check_eq({tag, "_cnt0"}, 32'(cnt0), e0);
    check_eq({tag, "_cnt5"}, 32'(cnt5), e5);
    check_eq({tag, "_cnt9"}, 32'(cnt9), e9);
    c0 = int'(cnt0); c5 = int'(cnt5); c9 = int'(cnt9);
    step();
    check_eq({tag, "_done_pulse"}, 32'(done), 0);
    check_eq({tag, "_idle"}, 32'(dbg_state), 32'(ST_IDLE));
    check_eq({tag, "_len_kept"}, 32'(len), plen);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c0, c5, c9, r0, r5, r9, n;
    bit saw_done;

    // Reset then idle start with nothing loaded.
    rst_b = 1'b0;
    step(); step();
    check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check_eq("rst_ai", 32'({a_out, i_out}), 0);
    check_eq("rst_dut_rst_b", 32'(dut_rst_b), 1);
    check_eq("rst_flags", 32'({busy, done, err, full}), 0);
    check_eq("rst_len", 32'(len), 0);
    check_eq("rst_cnts", 32'({cnt0, cnt5, cnt9}), 0);
    rst_b = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("empty_start_err", 32'(err), 1);
    check_eq("empty_start_busy", 32'(busy), 0);
    step();
    check_eq("empty_err_pulse", 32'(err), 0);
    check_eq("empty_busy", 32'(busy), 0);

    // Loopback 1: H2->D5->D5->F6->F6.
    do_ld(1, 0); do_ld(0, 0); do_ld(0, 1); do_ld(0, 0);
    run_check("lb1", 0, 0, 0, 0, c0, c5, c9);
    check_eq("lb1_spec_cnt0", c0, 3);
    check_eq("lb1_spec_cnt5", c5, 2);
    check_eq("lb1_spec_cnt9", c9, 3);

    // clr has priority over a same-cycle ld.
    clr = 1'b1; ld = 1'b1; ld_a = 1'b1; ld_i = 1'b1;
    step();
    clr = 1'b0; ld = 1'b0;
    exp_q.delete();
    check_eq("clr_prio_len", 32'(len), 0);
    check_eq("clr_prio_err", 32'(err), 0);

    // Loopback 2: H2->V8->O8->F6.
    do_clr();
    do_ld(0, 0); do_ld(0, 0); do_ld(1, 1);
    run_check("lb2", 0, 0, 0, 0, c0, c5, c9);
    check_eq("lb2_spec_cnt0", c0, 1);
    check_eq("lb2_spec_cnt5", c5, 1);
    check_eq("lb2_spec_cnt9", c9, 1);

    // Full store: DEPTH random steps, then one extra.
    do_clr();
    for (int k = 0; k < DEPTH; k++) do_ld(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check_eq("full_flag", 32'(full), 1);
    check_eq("full_len", 32'(len), DEPTH);
    do_ld(1, 1);
    step();
    check_eq("full_err_pulse", 32'(err), 0);
    run_check("full_run", 0, 0, 0, 0, r0, r5, r9);

    // Replay without reload while pulsing ld/clr/start mid-run.
    run_check("replay", 1, 0, 0, 0, c0, c5, c9);
    check_eq("replay_cnt0", c0, r0);
    check_eq("replay_cnt5", c5, r5);
    check_eq("replay_cnt9", c9, r9);

    // Random patterns; last step loaded in the same cycle as start
    // (covers start from an empty store when the length is 1).
    for (int it = 0; it < 8; it++) begin
      do_clr();
      n = $urandom_range(1, DEPTH);
      for (int k = 0; k < n - 1; k++) do_ld(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      run_check("rand", 0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), c0, c5, c9);
    end

    // Reset in the 2nd RUN cycle.
    do_clr();
    for (int k = 0; k < 5; k++) do_ld(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    start = 1'b1;
    step();            // PRE
    start = 1'b0;
    step();            // RUN cycle 0
    step();            // RUN cycle 1
    check_eq("mid_busy_before", 32'(busy), 1);
    rst_b = 1'b0;
    step();
    rst_b = 1'b1;
    exp_q.delete();
    check_eq("mid_state", 32'(dbg_state), 32'(ST_IDLE));
    check_eq("mid_len", 32'(len), 0);
    check_eq("mid_cnts", 32'({cnt0, cnt5, cnt9}), 0);
    check_eq("mid_busy", 32'(busy), 0);
    check_eq("mid_dut_rst_b", 32'(dut_rst_b), 1);
    saw_done = done;
    for (int k = 0; k < 8; k++) begin
      step();
      saw_done |= done;
    end
    check_eq("mid_no_done", 32'(saw_done), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
